s_mem_reader: RTL and testbench

//  Reader for the 256x8 S-array memory that the init block fills. Sweeps a

---
 rtl/s_mem_reader.sv | 116 +++++++++++
 tb/tb_s_mem_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_mem_reader.sv
// Reader for the 256x8 S-array: sweeps an address range onto a valid/ready stream with a 16-bit checksum.
// Optional permutation check is compiled in with `define SMR_CHECK_PERM_EN.
module s_mem_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rddata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       checksum,
  output logic              done,
  output logic              perm_ok
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE   = 3'd1;
  localparam logic [2:0] CAPT    = 3'd2;
  localparam logic [2:0] PRESENT = 3'd3;
  localparam logic [2:0] FIN     = 3'd4;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);

  logic [2:0]      state;
  logic [ADDR_W:0] remain;
  logic [ADDR_W:0] len_sat;
  logic            accept;
  logic            handshake;

  function automatic logic [ADDR_W:0] sat_len(input logic [ADDR_W:0] l);
    return (l > DEPTH_L) ? DEPTH_L : l;
  endfunction

  // FIN also reports ready, so a new sweep may start straight out of it
  assign rdy       = (state == IDLE) || (state == FIN);
  assign done      = (state == FIN);
  assign accept    = rdy && en;
  assign handshake = (state == PRESENT) && out_ready;
  assign len_sat   = sat_len(len);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      checksum  <= '0;
      remain    <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (en) begin
            addr     <= start_addr;
            remain   <= len_sat;
            checksum <= '0;
            state    <= (len_sat == '0) ? FIN : ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: state <= CAPT;
        // memory answers one cycle after addr, so the byte is captured here
        CAPT: begin
          out_data  <= rddata;
          out_valid <= 1'b1;
          state     <= PRESENT;
        end
        PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            checksum  <= checksum + 16'(out_data);
            addr      <= (addr == LAST) ? '0 : addr + A_ONE;
            remain    <= remain - CNT_ONE;
            state     <= (remain == CNT_ONE) ? FIN : ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SMR_CHECK_PERM_EN
  logic [DEPTH-1:0] seen;
  logic             full_len;

  // a full sweep that touched every byte value means the array is a permutation
  always_ff @(posedge clk) begin
    if (rst) begin
      seen     <= '0;
      full_len <= 1'b0;
      perm_ok  <= 1'b0;
    end else if (accept) begin
      seen     <= '0;
      full_len <= (len_sat == DEPTH_L);
      perm_ok  <= 1'b0;
    end else begin
      if (handshake) seen[out_data] <= 1'b1;
      if (state == FIN) perm_ok <= full_len && (&seen);
    end
  end
`else
  assign perm_ok = 1'b0;
`endif

endmodule

// File: tb/tb_s_mem_reader.sv
// Randomised scoreboard bench for s_mem_reader; expected bytes come from a plain array model of the sweep.
module tb_s_mem_reader;

  typedef struct {
    logic [7:0] d;
    logic [7:0] a;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, en, rdy, out_valid, out_ready, done, perm_ok;
  logic [7:0]  start_addr, addr, rddata, out_data;
  logic [8:0]  len;
  logic [15:0] checksum;
  logic [7:0]  mem [0:255];

  int n_checks = 0;
  int n_fail = 0;
  int done_count = 0;
  int delivered = 0;

  beat_t       exp_q[$];
  logic [15:0] sum_q[$];
  beat_t       mb;
  logic        prev_valid = 1'b0, prev_hs = 1'b0, hs;
  logic [7:0]  prev_data = '0, prev_addr = '0;

  s_mem_reader #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .start_addr(start_addr), .len(len),
    .addr(addr), .rddata(rddata), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .checksum(checksum), .done(done), .perm_ok(perm_ok)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rddata <= mem[addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  // Monitor: pops the scoreboard on every accepted byte and on every done pulse
  always @(negedge clk) begin
    if (out_valid && prev_valid && !prev_hs) begin
      chk("hold_data", out_data, prev_data);
      chk("hold_addr", addr, prev_addr);
    end
    hs = out_valid && out_ready;
    if (hs) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_byte: got %0h expected none", out_data);
      end else begin
        mb = exp_q.pop_front();
        chk("data", out_data, mb.d);
        chk("addr", addr, mb.a);
      end
      delivered++;
    end
    if (done) begin
      done_count++;
      if (sum_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got 1 expected 0");
      end else begin
        chk("checksum", checksum, sum_q.pop_front());
        chk("all_bytes_delivered", exp_q.size(), 0);
      end
    end
    prev_valid = out_valid;
    prev_hs    = hs;
    prev_data  = out_data;
    prev_addr  = addr;
  end

  task automatic wait_rdy();
    for (int k = 0; k < 100; k++) begin
      if (rdy) return;
      @(posedge clk); #1;
    end
    flag_fail("wait_rdy");
  endtask

  // mode 0: ready held, 1: random ready, 2: ready low for 10 cycles, 3: stray en mid-sweep
  task automatic wait_done(input int start, input int mode);
    bit ok = 0;
    for (int k = 0; k < 20000; k++) begin
      @(posedge clk); #1;
      if (done_count != start) begin
        ok = 1;
        break;
      end
      case (mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: out_ready = !(k >= 30 && k < 40);
        default: out_ready = 1'b1;
      endcase
      en = (mode == 3 && k == 20);
      if (en) begin
        start_addr = 8'($urandom);
        len = 9'd1;
      end
    end
    en = 1'b0;
    out_ready = 1'b1;
    if (!ok) flag_fail("wait_done");
  endtask

  task automatic load_expect(input logic [7:0] sa, input logic [8:0] ln,
                             output logic [15:0] s, output bit full);
    int eff;
    bit seen[256];
    beat_t b;
    eff = (ln > 9'd256) ? 256 : int'(ln);
    s = '0;
    for (int i = 0; i < 256; i++) seen[i] = 0;
    for (int i = 0; i < eff; i++) begin
      b.a = 8'((int'(sa) + i) % 256);
      b.d = mem[b.a];
      exp_q.push_back(b);
      s += 16'(b.d);
      seen[b.d] = 1;
    end
    full = (eff == 256);
    for (int i = 0; i < 256; i++) if (!seen[i]) full = 0;
    sum_q.push_back(s);
  endtask

  task automatic run_sweep(input logic [7:0] sa, input logic [8:0] ln, input int mode, input bit lat_chk);
    logic [15:0] s;
    bit full;
    int start, dc;
    load_expect(sa, ln, s, full);
    wait_rdy();
    out_ready = 1'b1;
    start = done_count;
    en = 1'b1;
    start_addr = sa;
    len = ln;
    @(posedge clk); #1;
    en = 1'b0;
    if (ln == 9'd0) begin
      @(negedge clk);
      chk("len0_done", done, 1);
      chk("len0_valid", out_valid, 0);
    end else if (lat_chk) begin
      @(negedge clk);
      @(negedge clk);
      chk("latency_c2", out_valid, 0);
      @(negedge clk);
      chk("latency_c3", out_valid, 1);
    end
    wait_done(start, mode);
`ifdef SMR_CHECK_PERM_EN
    chk("perm_ok", perm_ok, full);
`else
    chk("perm_ok", perm_ok, 0);
`endif
    dc = done_count;
    repeat (4) @(posedge clk);
    #1;
    chk("checksum_frozen", checksum, s);
    chk("no_extra_done", done_count, dc);
    chk("idle_rdy", rdy, 1);
  endtask

  task automatic reset_mid();
    logic [15:0] s;
    bit full;
    int target, dc;
    load_expect(8'h00, 9'd256, s, full);
    wait_rdy();
    out_ready = 1'b1;
    target = delivered + 5;
    en = 1'b1;
    start_addr = 8'h00;
    len = 9'd256;
    @(posedge clk); #1;
    en = 1'b0;
    for (int k = 0; k < 200 && delivered < target; k++) begin
      @(posedge clk); #1;
    end
    if (delivered < target) flag_fail("reset_wait");
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    sum_q.delete();
    @(negedge clk);
    chk("rst_mid_rdy", rdy, 1);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_checksum", checksum, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_perm", perm_ok, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dc = done_count;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_mid_no_done", done_count, dc);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    rst = 1'b1;
    en = 1'b0;
    out_ready = 1'b1;
    start_addr = '0;
    len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rdy", rdy, 1);
    chk("reset_addr", addr, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_checksum", checksum, 0);
    chk("reset_done", done, 0);
    chk("reset_perm", perm_ok, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_sweep(8'h00, 9'd256, 0, 1'b1);
    chk("identity_sum", checksum, 16'h7F80);
    run_sweep(8'hFE, 9'd4, 0, 1'b0);
    chk("wrap_sum", checksum, 16'h01FE);
    run_sweep(8'h00, 9'd256, 2, 1'b0);
    run_sweep(8'h33, 9'd0, 0, 1'b0);
    chk("len0_sum", checksum, 16'h0000);
    reset_mid();
    run_sweep(8'h10, 9'd20, 1, 1'b0);
    mem[8'h11] = 8'h10;
    run_sweep(8'h00, 9'd256, 3, 1'b0);

    // shuffled permutation swept from an odd start with an oversize length
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      int j;
      logic [7:0] t;
      j = $urandom_range(0, i);
      t = mem[i];
      mem[i] = mem[j];
      mem[j] = t;
    end
    run_sweep(8'($urandom), 9'd300, 1, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      run_sweep(8'($urandom), 9'($urandom_range(0, 300)), 1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
